// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM encodings, strobe polarity and request record.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_DONE = 2'd2
    } dmState_t;

    // MemRead/MemWrite are active-low: 0 requests an access.
    localparam logic MEM_ACTIVE = 1'b0;

    typedef struct packed {
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] data;
    } dmReq_t;

endpackage

// File: rtl/data_mem_responder_byte_ram.sv
// dm_byte_ram: byte-organised big-endian RAM with async clear and one 4-byte word port.
// Byte indices wrap modulo DEPTH_BYTES, so the top word continues at byte 0.
module dm_byte_ram #(
    parameter int DEPTH_BYTES = 128,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          wrEn,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wrData,
    output logic [31:0]   rdData
);

    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= '0;
        end else if (wrEn) begin
            // AW-bit index arithmetic gives the wrap for free
            for (int k = 0; k < 4; k++) mem[addr + AW'(k)] <= wrData[31-8*k -: 8];
        end
    end

    always_comb begin
        rdData = '0;
        for (int k = 0; k < 4; k++) rdData[31-8*k -: 8] = mem[addr + AW'(k)];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for LW/SW with programmable wait latency and a Busy stall request.
// Build option: define DM_ALIGN_CHECK_EN to suppress and flag accesses with DAddr[1:0] != 0.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Busy,
    output logic        Done,
    output logic        AlignErr
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    dmState_t    state, nextState;
    logic [3:0]  counter;
    dmReq_t      capReq, liveReq, curReq;
    logic        request, commit, misaligned, ramWrEn;
    logic [31:0] ramRd;
    logic        unusedAddrBits;

    assign request = (MemRead == MEM_ACTIVE) | (MemWrite == MEM_ACTIVE);
    // Write wins when both strobes are active
    assign liveReq = '{isWrite: (MemWrite == MEM_ACTIVE), addr: DAddr, data: DataIn};
    // With zero latency the commit edge is the acceptance edge, so live inputs are used
    assign curReq  = (state == DM_IDLE) ? liveReq : capReq;
    assign commit  = (nextState == DM_DONE);
    assign unusedAddrBits = ^curReq.addr[31:AW];

`ifdef DM_ALIGN_CHECK_EN
    assign misaligned = (curReq.addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign ramWrEn = commit & curReq.isWrite & ~misaligned;

    dm_byte_ram #(.DEPTH_BYTES(DEPTH_BYTES), .AW(AW)) uRam (
        .CLK    (CLK),
        .Reset  (Reset),
        .wrEn   (ramWrEn),
        .addr   (curReq.addr[AW-1:0]),
        .wrData (curReq.data),
        .rdData (ramRd)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= DM_IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        Busy      = 1'b0;
        case (state)
            DM_IDLE: if (request) begin
                Busy      = 1'b1;
                nextState = (LATENCY == 0) ? DM_DONE : DM_WAIT;
            end
            DM_WAIT: begin
                Busy = 1'b1;
                if (counter == 4'd0) nextState = DM_DONE;
            end
            DM_DONE: nextState = DM_IDLE;
            default: nextState = DM_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            counter  <= '0;
            capReq   <= '0;
            DataOut  <= '0;
            Done     <= 1'b0;
            AlignErr <= 1'b0;
        end else begin
            Done     <= commit;
            AlignErr <= commit & misaligned;
            if (state == DM_IDLE && request) begin
                capReq  <= liveReq;
                counter <= WAIT_INIT;
            end else if (state == DM_WAIT && counter != 4'd0) begin
                counter <= counter - 4'd1;
            end
            if (commit && !curReq.isWrite && !misaligned) DataOut <= ramRd;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: LATENCY=2 main instance plus a LATENCY=0 instance.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int DEPTH = 128;
    localparam int LAT   = 2;
`ifdef DM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        alignErr;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        MemRead, MemWrite;
    logic [31:0] DAddr, DataIn, DataOut;
    logic        Busy, Done, AlignErr;
    logic        memRead0, memWrite0;
    logic [31:0] dAddr0, dataIn0, dataOut0;
    logic        busy0, done0, alignErr0;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  model [DEPTH];
    logic [31:0] lastOut;
    exp_t        sbQ[$];

    always #5 CLK = ~CLK;

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .DAddr(DAddr), .DataIn(DataIn), .DataOut(DataOut),
        .Busy(Busy), .Done(Done), .AlignErr(AlignErr)
    );

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(0)) dut0 (
        .CLK(CLK), .Reset(Reset), .MemRead(memRead0), .MemWrite(memWrite0),
        .DAddr(dAddr0), .DataIn(dataIn0), .DataOut(dataOut0),
        .Busy(busy0), .Done(done0), .AlignErr(alignErr0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelIssue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic mis;
        int   base;
        mis  = ALIGN && (a[1:0] != 2'b00);
        base = int'(a % DEPTH);
        if (!mis) begin
            if (wr) begin
                for (int k = 0; k < 4; k++) model[(base + k) % DEPTH] = d[31-8*k -: 8];
            end else if (rd) begin
                for (int k = 0; k < 4; k++) lastOut[31-8*k -: 8] = model[(base + k) % DEPTH];
            end
        end
        sbQ.push_back('{lastOut, mis});
    endtask

    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input bit scramble);
        int busyCnt;
        bit gotDone;
        busyCnt = 0;
        gotDone = 1'b0;
        @(negedge CLK);
        MemRead  = rd ? MEM_ACTIVE : ~MEM_ACTIVE;
        MemWrite = wr ? MEM_ACTIVE : ~MEM_ACTIVE;
        DAddr    = a;
        DataIn   = d;
        modelIssue(rd, wr, a, d);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (Done) begin
                gotDone = 1'b1;
                chk({tag, "_busyInDone"}, 32'(Busy), 32'd0);
                break;
            end
            if (Busy) busyCnt++;
            @(posedge CLK);
            #1;
            MemRead  = ~MEM_ACTIVE;
            MemWrite = ~MEM_ACTIVE;
            if (scramble) begin
                DAddr  = $urandom;
                DataIn = $urandom;
            end
            @(negedge CLK);
        end
        chk({tag, "_done"}, 32'(gotDone), 32'd1);
        chk({tag, "_busyCycles"}, 32'(busyCnt), 32'(LAT + 1));
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (Done) begin
            if (sbQ.size() == 0) begin
                chk("sb_unexpectedDone", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                chk("sb_dataOut", DataOut, e.data);
                chk("sb_alignErr", 32'(AlignErr), 32'(e.alignErr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        MemRead = 1'b1; MemWrite = 1'b1; DAddr = '0; DataIn = '0;
        memRead0 = 1'b1; memWrite0 = 1'b1; dAddr0 = '0; dataIn0 = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        lastOut = '0;

        #1 Reset = 1'b1;
        #2;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_dataOut", DataOut, 32'd0);
        chk("rst_alignErr", 32'(AlignErr), 32'd0);
        @(negedge CLK) Reset = 1'b0;

        // basic store/load and byte order
        access("sw8", 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0);
        access("lw8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        chk("lw8_val", DataOut, 32'hDEADBEEF);
        access("lw9", 1'b1, 1'b0, 32'h9, 32'h0, 1'b0);
        chk("lw9_val", DataOut, ALIGN ? 32'hDEADBEEF : 32'hADBEEF00);

        // wrap around the top of the array
        access("sw7e", 1'b0, 1'b1, 32'h7E, 32'h11223344, 1'b0);
        access("lw0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("lw0_wrap", DataOut, ALIGN ? 32'h0 : 32'h33440000);
        access("lw7c", 1'b1, 1'b0, 32'h7C, 32'h0, 1'b0);
        chk("lw7c_wrap", DataOut, ALIGN ? 32'h0 : 32'h00001122);
        access("lwHigh", 1'b1, 1'b0, 32'hFFFF_FF88, 32'h0, 1'b0);
        chk("lwHigh_val", DataOut, 32'hDEADBEEF);

        // both strobes: write wins, inputs scrambled during WAIT
        access("both", 1'b1, 1'b1, 32'h10, 32'h5, 1'b1);
        chk("both_keep", DataOut, 32'hDEADBEEF);
        access("lw10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        chk("lw10_val", DataOut, 32'h00000005);

        // reset during WAIT aborts the store and clears RAM
        access("sw20", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0);
        access("lw20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        chk("lw20_val", DataOut, 32'hCAFEF00D);
        @(negedge CLK);
        MemWrite = MEM_ACTIVE; DAddr = 32'h20; DataIn = 32'h01020304;
        @(posedge CLK);
        #1 MemWrite = ~MEM_ACTIVE;
        #2 Reset = 1'b1;
        #1;
        chk("rstWait_busy", 32'(Busy), 32'd0);
        chk("rstWait_done", 32'(Done), 32'd0);
        chk("rstWait_dataOut", DataOut, 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        lastOut = '0;
        sbQ.delete();
        @(negedge CLK) Reset = 1'b0;
        access("lw20b", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        chk("lw20b_val", DataOut, 32'h0);

        // zero-latency instance: store, then held read strobe
        @(negedge CLK);
        memWrite0 = MEM_ACTIVE; dAddr0 = 32'h4; dataIn0 = 32'h12345678;
        #1 chk("l0_sw_busy", 32'(busy0), 32'd1);
        @(posedge CLK);
        #1 memWrite0 = ~MEM_ACTIVE;
        @(negedge CLK);
        chk("l0_sw_done", 32'(done0), 32'd1);
        chk("l0_sw_busyDone", 32'(busy0), 32'd0);
        chk("l0_sw_dataOut", dataOut0, 32'd0);
        @(negedge CLK);
        memRead0 = MEM_ACTIVE;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("l0_lw_busyIdle", 32'(busy0), 32'd1);
            chk("l0_lw_doneIdle", 32'(done0), 32'd0);
            @(negedge CLK);
            chk("l0_lw_done", 32'(done0), 32'd1);
            chk("l0_lw_busyDone", 32'(busy0), 32'd0);
            chk("l0_lw_dataOut", dataOut0, 32'h12345678);
            chk("l0_lw_alignErr", 32'(alignErr0), 32'd0);
            @(negedge CLK);
        end
        memRead0 = ~MEM_ACTIVE;

        repeat (3) @(negedge CLK);
        chk("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
